// File: rtl/music_sequencer_if.sv
// Command, ROM and output signals between the music sequencer and its surroundings.
// "master" is the sequencer side; "slave" is the controller/ROM/tone-generator side.
interface music_seq_if;
  logic       play;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo;
  logic [7:0] address;
  logic [7:0] rom_note;
  logic [7:0] note_out;
  logic       sound_en;
  logic       playing;
  logic       song_done;

  modport master (
    input  play, pause, stop, loop_en, tempo, rom_note,
    output address, note_out, sound_en, playing, song_done
  );

  modport slave (
    output play, pause, stop, loop_en, tempo, rom_note,
    input  address, note_out, sound_en, playing, song_done
  );
endinterface

// File: rtl/music_sequencer.sv
// Playback controller: steps music ROM addresses at a selectable tempo and gates
// sound for rests, articulation gaps and play/pause/stop commands.
module music_sequencer #(
  parameter int TICK_DIV   = 2**24,
  parameter int GAP_CYCLES = 65536,
  parameter int SONG_LEN   = 241
) (
  input  logic       clk,
  input  logic       rst,
  music_seq_if.master bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = TW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tick;
  logic [LW-1:0]   r_cur_len;
  logic [7:0]      r_addr;
  logic [7:0]      r_note;
  logic            r_sound;
  logic            r_playing;
  logic            r_done;

  logic            w_stop;
  logic            w_play;
  logic            w_pause;
  logic [LW-1:0]   w_step_len;
  logic [LW-1:0]   w_tick_ext;
  logic            w_last_tick;
  logic            w_last_addr;
  logic            w_sound_ok;

  assign w_stop      = bus.stop;
  assign w_play      = bus.play & ~bus.stop;
  assign w_pause     = bus.pause & ~bus.stop & ~bus.play;
  assign w_step_len  = LW'(TICK_DIV) >> bus.tempo;
  assign w_tick_ext  = {1'b0, r_tick};
  assign w_last_tick = (w_tick_ext == (r_cur_len - LW'(1)));
  assign w_last_addr = (r_addr >= 8'(SONG_LEN - 1));

  // Tick 0 of a step still sees the previous address's ROM data, so it is masked.
  assign w_sound_ok  = (r_state == S_PLAY) && (r_tick != '0) &&
                       (w_tick_ext < (r_cur_len - LW'(GAP_CYCLES))) &&
                       (bus.rom_note != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_cur_len <= LW'(TICK_DIV);
      r_addr    <= 8'd0;
      r_note    <= 8'd0;
      r_sound   <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_note  <= bus.rom_note;
      r_done  <= 1'b0;
      r_sound <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_addr    <= 8'd0;
        r_tick    <= '0;
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_play) begin
              r_state   <= S_PLAY;
              r_addr    <= 8'd0;
              r_tick    <= '0;
              r_cur_len <= w_step_len;
              r_playing <= 1'b1;
            end
          end
          S_PAUSE: begin
            if (w_play) r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_pause) begin
              r_state <= S_PAUSE;
            end else begin
              r_sound <= w_sound_ok;
              if (w_last_tick) begin
                // Tempo only takes effect at step boundaries.
                r_tick    <= '0;
                r_cur_len <= w_step_len;
                if (!w_last_addr) begin
                  r_addr <= r_addr + 8'd1;
                end else begin
                  r_done <= 1'b1;
                  r_addr <= 8'd0;
                  if (!bus.loop_en) begin
                    r_state   <= S_DONE;
                    r_playing <= 1'b0;
                  end
                end
              end else begin
                r_tick <= r_tick + TW'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.address   = r_addr;
  assign bus.note_out  = r_note;
  assign bus.sound_en  = r_sound;
  assign bus.playing   = r_playing;
  assign bus.song_done = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a small song (64-cycle steps, 2-cycle gap,
// 4 steps) and a behavioural synchronous ROM returning address+20.
module tb_music_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rest_on = 1'b0;

  always #5 clk = ~clk;

  music_seq_if bus();

  music_sequencer #(
    .TICK_DIV  (64),
    .GAP_CYCLES(2),
    .SONG_LEN  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) bus.rom_note <= 8'd0;
    else     bus.rom_note <= (rest_on && bus.address == 8'd2) ? 8'd0 : bus.address + 8'd20;
  end

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] note;
    logic       snd;
    logic       ply;
    logic       dn;
  } vec_t;

  vec_t tv[15];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ec = 0;
  int   scnt[4];
  bit   cnt_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {13'd0, bus.address, bus.note_out, bus.sound_en, bus.playing, bus.song_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
    if (cnt_en && ec >= 1 && ec <= 256 && bus.sound_en === 1'b1) scnt[(ec-1)/64]++;
  endtask

  task automatic run_to(input int t);
    while (ec < t) step();
  endtask

  task automatic start_play();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
    step();
    bus.play = 1'b1;
    step();
    bus.play = 1'b0;
    ec = 0;
    for (int i = 0; i < 4; i++) scnt[i] = 0;
  endtask

  initial begin
    int base;
    int hi;

    tv[0]  = '{0,   8'd0, 8'd20, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1,   8'd0, 8'd20, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{2,   8'd0, 8'd20, 1'b1, 1'b1, 1'b0};
    tv[3]  = '{62,  8'd0, 8'd20, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{63,  8'd0, 8'd20, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{64,  8'd1, 8'd20, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{65,  8'd1, 8'd20, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{66,  8'd1, 8'd21, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{127, 8'd1, 8'd21, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{130, 8'd2, 8'd22, 1'b1, 1'b1, 1'b0};
    tv[10] = '{194, 8'd3, 8'd23, 1'b1, 1'b1, 1'b0};
    tv[11] = '{255, 8'd3, 8'd23, 1'b0, 1'b1, 1'b0};
    tv[12] = '{256, 8'd0, 8'd23, 1'b0, 1'b0, 1'b1};
    tv[13] = '{257, 8'd0, 8'd23, 1'b0, 1'b0, 1'b0};
    tv[14] = '{258, 8'd0, 8'd20, 1'b0, 1'b0, 1'b0};

    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.loop_en = 1'b0; bus.tempo = 2'd0;

    // Reset state
    #1 rst = 1'b1;
    #1 check("reset_outputs", snap(), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Normal playback, loop off
    start_play();
    cnt_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      run_to(tv[i].cyc);
      check($sformatf("play_c%0d", tv[i].cyc), snap(),
            {13'd0, tv[i].addr, tv[i].note, tv[i].snd, tv[i].ply, tv[i].dn});
    end
    for (int s = 0; s < 4; s++) check($sformatf("sound_cycles_step%0d", s), scnt[s], 61);
    run_to(300);
    check("done_hold", snap(), {13'd0, 8'd0, 8'd20, 1'b0, 1'b0, 1'b0});

    // Rest at address 2
    rest_on = 1'b1;
    start_play();
    run_to(128); check("rest_addr_c128", bus.address, 8'd2);
    run_to(191); check("rest_addr_c191", bus.address, 8'd2);
    run_to(192); check("rest_addr_c192", bus.address, 8'd3);
    run_to(257);
    check("rest_step0", scnt[0], 61);
    check("rest_step1", scnt[1], 61);
    check("rest_step2", scnt[2], 0);
    check("rest_step3", scnt[3], 61);
    cnt_en = 1'b0;
    rest_on = 1'b0;

    // Loop enabled
    bus.loop_en = 1'b1;
    start_play();
    run_to(256); check("loop_wrap", {bus.address, bus.playing, bus.song_done}, {8'd0, 1'b1, 1'b1});
    run_to(257); check("loop_after", {bus.address, bus.playing, bus.song_done}, {8'd0, 1'b1, 1'b0});
    run_to(320); check("loop_addr1", {bus.address, bus.playing}, {8'd1, 1'b1});
    bus.loop_en = 1'b0;

    // Pause at tick 10 of address 1, hold, resume
    start_play();
    run_to(74);
    check("pause_pre", bus.address, 8'd1);
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    check("pause_enter", {bus.address, bus.sound_en, bus.playing}, {8'd1, 1'b0, 1'b1});
    repeat (100) step();
    check("pause_hold", {bus.address, bus.sound_en, bus.playing}, {8'd1, 1'b0, 1'b1});
    bus.play = 1'b1; step(); bus.play = 1'b0;
    base = ec;
    check("resume_snd0", bus.sound_en, 1'b0);
    step();
    check("resume_snd1", bus.sound_en, 1'b1);
    run_to(base + 53); check("resume_c53", bus.address, 8'd1);
    run_to(base + 54); check("resume_c54", bus.address, 8'd2);

    // Tempo change mid-step 1
    start_play();
    run_to(70);
    bus.tempo = 2'd2;
    run_to(127); check("tempo_c127", bus.address, 8'd1);
    run_to(128); check("tempo_c128", bus.address, 8'd2);
    hi = 0;
    while (ec < 144) begin
      step();
      if (bus.sound_en === 1'b1) hi++;
      if (ec == 143) check("tempo_c143", bus.address, 8'd2);
      if (ec == 144) check("tempo_c144", bus.address, 8'd3);
    end
    check("tempo_sound13", hi, 13);
    run_to(160); check("tempo_end", {bus.address, bus.playing, bus.song_done}, {8'd0, 1'b0, 1'b1});
    bus.tempo = 2'd0;

    // stop+play together while paused
    start_play();
    run_to(80);
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    bus.stop = 1'b1; bus.play = 1'b1; step();
    bus.stop = 1'b0; bus.play = 1'b0;
    check("stopplay_idle", {bus.address, bus.sound_en, bus.playing}, {8'd0, 1'b0, 1'b0});
    step(); step();
    check("stopplay_stays", {bus.address, bus.playing}, {8'd0, 1'b0});

    // Asynchronous reset mid-play
    start_play();
    run_to(80);
    check("pre_rst", {bus.address, bus.sound_en, bus.playing}, {8'd1, 1'b1, 1'b1});
    #1 rst = 1'b1;
    #1 check("async_rst", snap(), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
